cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter: s_line, 256, line width in bits for all data buses.
REQ-002 The block SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: i_address  input  32  instruction-cache line-miss address.
REQ-005 The block SHALL have port: i_read  input  1  instruction-cache line-read request.
REQ-006 The block SHALL have port: i_rdata  output  s_line  line returned to the instruction cache.
REQ-007 The block SHALL have port: i_resp  output  1  instruction request complete, one-cycle pulse.
REQ-008 The block SHALL have port: d_address  input  32  data-cache line address.
REQ-009 The block SHALL have port: d_read  input  1  data-cache line-read request.
REQ-010 The block SHALL have port: d_write  input  1  data-cache writeback request.
REQ-011 The block SHALL have port: d_wdata  input  s_line  writeback line.
REQ-012 The block SHALL have port: d_rdata  output  s_line  line returned to the data cache.
REQ-013 The block SHALL have port: d_resp  output  1  data request complete, one-cycle pulse.
REQ-014 The block SHALL have ports: pmem_address output 32, pmem_read output 1, pmem_write output 1, pmem_wdata output s_line, pmem_rdata input s_line, pmem_resp input 1 -- the single shared physical-memory port.

Function
REQ-015 The FSM SHALL have states IDLE, SERVE_I, SERVE_D, DONE.
REQ-016 In IDLE, if only i_read is high, the FSM SHALL go to SERVE_I; if only (d_read|d_write) is high, SERVE_D; if neither, it SHALL stay in IDLE.
REQ-017 In IDLE with both requesting, the FSM SHALL grant the requester not recorded in last_grant (round-robin); last_grant SHALL update on every IDLE->SERVE_* transition.
REQ-018 On the IDLE->SERVE_* edge, the block SHALL latch the served requester's address into addr_q, and d_wdata into wdata_q and d_write into wr_q for SERVE_D.
REQ-019 pmem_address SHALL equal addr_q and pmem_wdata SHALL equal wdata_q in every state.
REQ-020 In SERVE_I, pmem_read SHALL be 1 and pmem_write SHALL be 0.
REQ-021 In SERVE_D, pmem_write SHALL be wr_q and pmem_read SHALL be !wr_q; write takes precedence if d_read and d_write were both high at grant.
REQ-022 In IDLE and DONE, pmem_read and pmem_write SHALL be 0.
REQ-023 Latency: a request first seen in IDLE at cycle N SHALL drive a pmem command at cycle N+1.
REQ-024 i_resp SHALL equal pmem_resp & (state==SERVE_I), and d_resp SHALL equal pmem_resp & (state==SERVE_D), both combinational.
REQ-025 i_rdata and d_rdata SHALL equal pmem_rdata continuously.
REQ-026 The FSM SHALL leave SERVE_* only on pmem_resp, going to DONE; DONE SHALL go to IDLE unconditionally, giving the requester one cycle to deassert.
REQ-027 A requester input changing during SERVE_* SHALL NOT affect the pmem command, address or data until DONE.
REQ-028 Fairness: with both requesters continuously active, grants SHALL alternate I, D, I, D...; worst-case wait is one other transaction plus 2 cycles.
REQ-029 pmem_resp arriving in IDLE or DONE SHALL be ignored: no resp pulse and no state change.

Reset
REQ-030 rst SHALL force state=IDLE, last_grant=D (first tie goes to I), addr_q=0, wdata_q=0, wr_q=0.
REQ-031 While rst is high, all pmem_* command outputs and i_resp/d_resp SHALL be 0 from the next edge.
REQ-032 rst asserted mid-SERVE_* SHALL abandon the transaction without a response pulse.

Structure
REQ-033 A shared package SHALL hold the arb_state_t enum (IDLE, SERVE_I, SERVE_D, DONE) and the requester_t enum (REQ_I, REQ_D).
REQ-034 The block SHALL be one module with no sub-module; the round-robin pick SHALL be an always_comb section inside it.

Verification
REQ-035 I only: i_read=1 with i_address=0x0000_1040, pmem_resp after 5 cycles -> pmem_read=1 and pmem_address=0x1040 from N+1, i_resp one pulse, d_resp=0.
REQ-036 D writeback: d_write=1, d_address=0x8000_0020, d_wdata=all 0xA5 -> pmem_write=1 with wdata 0xA5..., d_resp pulse, pmem_read=0 throughout.
REQ-037 Tie after reset: i_read and d_read rise together -> I served first, then D after DONE and IDLE; a second tie then serves I.
REQ-038 Hold-stability: d_address changed to 0x1234 mid-SERVE_D -> pmem_address keeps the latched value until DONE.
REQ-039 Reset mid-op: rst in the 2nd SERVE_I cycle -> next cycle IDLE, pmem_read=0, no i_resp even if pmem_resp=1.
REQ-040 Stray response: pmem_resp=1 in IDLE -> i_resp=d_resp=0 and the state stays IDLE.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_arbiter_pkg;

  // Arbiter control states: wait for a request, serve one side, one idle cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Identifies which cache owns the memory port.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I- and D-cache.
// Latency: request seen in IDLE drives the pmem command on the next cycle.
// Backpressure: one transaction at a time; the loser waits until the winner's DONE.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_address/i_read              instruction-cache line read request
//   i_rdata/i_resp                instruction line return, one-cycle completion pulse
//   d_address/d_read/d_write/     data-cache line read or writeback request
//   d_wdata
//   d_rdata/d_resp                data line return, one-cycle completion pulse
//   pmem_*                        shared physical-memory command/response port
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,

  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,

  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  requester_t        last_grant;
  requester_t        grant;
  logic              grant_vld;
  logic              i_req;
  logic              d_req;
  logic [31:0]       addr_q;
  logic [s_line-1:0] wdata_q;
  logic              wr_q;

  // Round-robin pick: on a tie the side that did not win last time goes next.
  always_comb begin
    i_req     = i_read;
    d_req     = d_read | d_write;
    grant_vld = i_req | d_req;
    grant     = REQ_I;
    if (i_req && d_req) begin
      grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (d_req) begin
      grant = REQ_D;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = (grant == REQ_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I,
      SERVE_D: begin
        if (pmem_resp) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command and response outputs; responses outside SERVE_* are dropped.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
      end
      SERVE_D: begin
        pmem_write = wr_q;
        pmem_read  = ~wr_q;
        d_resp     = pmem_resp;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

  // Request fields are captured once at grant so requester changes during
  // service cannot disturb the memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_vld) begin
        last_grant <= grant;
        if (grant == REQ_I) begin
          addr_q <= i_address;
        end else begin
          addr_q  <= d_address;
          wdata_q <= d_wdata;
          wr_q    <= d_write;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic.
module tb_cache_arbiter;

  localparam int W = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_address;
  logic          i_read;
  logic [W-1:0]  i_rdata;
  logic          i_resp;
  logic [31:0]   d_address;
  logic          d_read;
  logic          d_write;
  logic [W-1:0]  d_wdata;
  logic [W-1:0]  d_rdata;
  logic          d_resp;
  logic [31:0]   pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [W-1:0]  pmem_wdata;
  logic [W-1:0]  pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter #(.s_line(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // owner: 0 = nobody, 1 = instruction cache, 2 = data cache.
  int           m_owner    = 0;
  bit           m_cooldown = 1'b0;   // the one dead cycle after a completion
  bit           m_prefer_i = 1'b1;   // who wins the next simultaneous request
  logic [31:0]  m_addr     = '0;
  logic [W-1:0] m_wdata    = '0;
  bit           m_wr       = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_cooldown = 0; m_prefer_i = 1; m_addr = '0; m_wdata = '0; m_wr = 0;
    end else if (m_cooldown) begin
      m_cooldown = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner    = 0;
        m_cooldown = 1;
      end
    end else begin
      if (i_read && (!(d_read || d_write) || m_prefer_i)) begin
        m_owner = 1; m_addr = i_address; m_prefer_i = 0;
      end else if (d_read || d_write) begin
        m_owner = 2; m_addr = d_address; m_wdata = d_wdata; m_wr = d_write; m_prefer_i = 1;
      end
    end
  end

  logic e_rd, e_wr, e_iresp, e_dresp;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_rd    = (m_owner == 1) || (m_owner == 2 && !m_wr);
      e_wr    = (m_owner == 2) && m_wr;
      e_iresp = (m_owner == 1) && pmem_resp;
      e_dresp = (m_owner == 2) && pmem_resp;
      chk("model_pmem_read",    W'(pmem_read),    W'(e_rd));
      chk("model_pmem_write",   W'(pmem_write),   W'(e_wr));
      chk("model_pmem_address", W'(pmem_address), W'(m_addr));
      chk("model_pmem_wdata",   pmem_wdata,       m_wdata);
      chk("model_i_resp",       W'(i_resp),       W'(e_iresp));
      chk("model_d_resp",       W'(d_resp),       W'(e_dresp));
      chk("model_i_rdata",      i_rdata,          pmem_rdata);
      chk("model_d_rdata",      d_rdata,          pmem_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
  endtask

  logic [W-1:0] pat;

  initial begin
    rst = 1; quiet();
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    repeat (3) cyc();
    cmp_en = 1;
    #1;
    chk("reset_pmem_read",  W'(pmem_read),    '0);
    chk("reset_pmem_write", W'(pmem_write),   '0);
    chk("reset_address",    W'(pmem_address), '0);
    chk("reset_wdata",      pmem_wdata,       '0);
    chk("reset_resp",       W'({i_resp, d_resp}), '0);
    rst = 0;

    // Instruction-only read, memory answers 5 cycles after the request.
    i_address = 32'h0000_1040; i_read = 1;
    #1 chk("i_only_idle_no_cmd", W'(pmem_read), '0);
    cyc();
    #1 chk("i_only_read_n1", W'(pmem_read), W'(1'b1));
    chk("i_only_addr_n1", W'(pmem_address), W'(32'h0000_1040));
    chk("i_only_write_n1", W'(pmem_write), '0);
    repeat (4) cyc();
    #1 chk("i_only_no_early_resp", W'(i_resp), '0);
    pat = {8{32'hDEAD_BEEF}};
    pmem_rdata = pat; pmem_resp = 1; i_read = 0;
    #1 chk("i_only_i_resp", W'(i_resp), W'(1'b1));
    chk("i_only_d_resp", W'(d_resp), '0);
    chk("i_only_rdata", i_rdata, pat);
    cyc();
    pmem_resp = 0;
    #1 chk("i_only_done_no_cmd", W'(pmem_read), '0);
    chk("i_only_done_no_resp", W'(i_resp), '0);
    cyc();

    // Data writeback, with the address changed while the write is in flight.
    d_address = 32'h8000_0020; d_wdata = {32{8'hA5}}; d_write = 1;
    cyc();
    #1 chk("d_wb_write", W'(pmem_write), W'(1'b1));
    chk("d_wb_read", W'(pmem_read), '0);
    chk("d_wb_wdata", pmem_wdata, {32{8'hA5}});
    chk("d_wb_addr", W'(pmem_address), W'(32'h8000_0020));
    d_address = 32'h0000_1234; d_wdata = '0; d_write = 0; d_read = 1;
    cyc();
    #1 chk("hold_addr", W'(pmem_address), W'(32'h8000_0020));
    chk("hold_write", W'(pmem_write), W'(1'b1));
    chk("hold_read", W'(pmem_read), '0);
    chk("hold_wdata", pmem_wdata, {32{8'hA5}});
    pmem_resp = 1; d_read = 0;
    #1 chk("d_wb_d_resp", W'(d_resp), W'(1'b1));
    chk("d_wb_i_resp", W'(i_resp), '0);
    cyc();
    pmem_resp = 0;
    #1 chk("hold_addr_done", W'(pmem_address), W'(32'h8000_0020));
    cyc();

    // Simultaneous requests after reset: I, then D, then I again.
    rst = 1; cyc(); cyc(); rst = 0;
    i_address = 32'h0000_0100; d_address = 32'h0000_0200; i_read = 1; d_read = 1;
    cyc();
    #1 chk("tie1_addr_i", W'(pmem_address), W'(32'h0000_0100));
    pmem_resp = 1; i_read = 0;
    cyc();
    pmem_resp = 0;
    cyc();
    #1 chk("tie1_idle_gap", W'(pmem_read), '0);
    cyc();
    #1 chk("tie1_then_d_addr", W'(pmem_address), W'(32'h0000_0200));
    chk("tie1_then_d_read", W'(pmem_read), W'(1'b1));
    pmem_resp = 1; d_read = 0;
    #1 chk("tie1_then_d_resp", W'(d_resp), W'(1'b1));
    cyc();
    pmem_resp = 0;
    cyc();
    i_address = 32'h0000_0300; d_address = 32'h0000_0400; i_read = 1; d_read = 1;
    cyc();
    #1 chk("tie2_addr_i", W'(pmem_address), W'(32'h0000_0300));
    pmem_resp = 1; quiet(); pmem_resp = 1;
    cyc();
    pmem_resp = 0;
    cyc();

    // Reset in the second SERVE_I cycle abandons the read silently.
    i_address = 32'h0000_0500; i_read = 1;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0; i_read = 0; pmem_resp = 1;
    #1 chk("rst_mid_read", W'(pmem_read), '0);
    chk("rst_mid_no_iresp", W'(i_resp), '0);
    chk("rst_mid_addr", W'(pmem_address), '0);

    // Stray response in IDLE is ignored and leaves the arbiter idle.
    cyc();
    #1 chk("stray_resp", W'({i_resp, d_resp}), '0);
    pmem_resp = 0; i_address = 32'h0000_0600; i_read = 1;
    #1 chk("stray_still_idle", W'(pmem_read), '0);
    cyc();
    #1 chk("stray_then_serve", W'(pmem_read), W'(1'b1));
    i_read = 0; pmem_resp = 1;
    cyc();
    pmem_resp = 0;
    cyc();

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 2000; n++) begin
      cyc();
      rst        = ($urandom_range(0, 99) == 0);
      i_read     = ($urandom_range(0, 2) != 0);
      d_read     = $urandom_range(0, 1);
      d_write    = ($urandom_range(0, 3) == 0);
      i_address  = $urandom;
      d_address  = $urandom;
      d_wdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pmem_resp  = ($urandom_range(0, 3) == 0);
    end
    cyc();
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
